swc_page_allocator_core: RTL

- Responder (allocator side) of the swcore page allocator request port. Serves alloc / free / force_free / set_usecnt requests from a single initiator.
- Tracks free pages in a LIFO free-page stack and keeps per-page use counts in a use-count RAM.
- Sits between swcore input/output blocks and the multiport memory page space; one transaction at a time, each completed with a one-cycle done pulse.

---
 rtl/swc_alloc_pkg.sv | 46 ++++
 rtl/swc_alloc_ram.sv | 40 ++++
 rtl/swc_page_allocator_core.sv | 295 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/swc_alloc_pkg.sv
`default_nettype none
// ============================================================================
// Module      : swc_alloc_pkg
// Description : Shared types for the swcore page allocator: controller state
//               encoding, request-type encoding, service priority order and
//               the arbitration helper that applies it.
// Revision    : 1.0 - initial release
// ============================================================================
package swc_alloc_pkg;

    typedef enum logic [2:0] {
        ST_INIT = 3'd0,
        ST_IDLE = 3'd1,
        ST_RD   = 3'd2,
        ST_WR   = 3'd3,
        ST_RESP = 3'd4
    } state_t;

    // The encoding doubles as the bit index of each request in the
    // request vector {set_usecnt, force_free, free, alloc}.
    typedef enum logic [1:0] {
        REQ_ALLOC        = 2'd0,
        REQ_FREE         = 2'd1,
        REQ_FORCE_FREE   = 2'd2,
        REQ_SET_USECOUNT = 2'd3
    } req_t;

    // Service order, highest priority in the most significant slot.
    localparam logic [7:0] c_req_prio = {REQ_FORCE_FREE, REQ_FREE,
                                         REQ_SET_USECOUNT, REQ_ALLOC};

    // Picks the highest-priority active request. Slots are scanned from
    // lowest to highest priority so the last hit wins.
    function automatic req_t f_pick_req(input logic [3:0] req_vec);
        req_t w_sel;
        w_sel = REQ_ALLOC;
        for (int k = 0; k < 4; k++) begin
            if (req_vec[c_req_prio[2*k +: 2]]) begin
                w_sel = req_t'(c_req_prio[2*k +: 2]);
            end
        end
        return w_sel;
    endfunction

endpackage
`default_nettype wire

// File: rtl/swc_alloc_ram.sv
`default_nettype none
// ============================================================================
// Module      : swc_alloc_ram
// Description : Single-clock simple dual-port RAM, one synchronous write port
//               and one synchronous read port with one cycle of latency.
//               A read of the address being written returns the old data.
// Ports       : clk      - clock
//               i_we     - write enable
//               i_waddr  - write address
//               i_wdata  - write data
//               i_raddr  - read address
//               o_rdata  - read data, registered
// Revision    : 1.0 - initial release
// ============================================================================
module swc_alloc_ram #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
) (
    input  wire logic              clk,
    input  wire logic              i_we,
    input  wire logic [ADDR_W-1:0] i_waddr,
    input  wire logic [DATA_W-1:0] i_wdata,
    input  wire logic [ADDR_W-1:0] i_raddr,
    output logic      [DATA_W-1:0] o_rdata
);

    logic [DATA_W-1:0] r_mem [1<<ADDR_W];
    logic [DATA_W-1:0] r_rdata;

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
        r_rdata <= r_mem[i_raddr];
    end

    assign o_rdata = r_rdata;

endmodule
`default_nettype wire

// File: rtl/swc_page_allocator_core.sv
`default_nettype none
// ============================================================================
// Module      : swc_page_allocator_core
// Description : Allocator side of the swcore page allocator request port.
//               Keeps free pages on a LIFO stack and per-page use counts in a
//               RAM; serves one alloc / free / force_free / set_usecnt
//               transaction at a time (IDLE -> RD -> WR -> RESP) and ends each
//               with a one-cycle done pulse.
// Ports       : clk_i, rst_n_i (async, active-low)
//               alloc_i, free_i, force_free_i, set_usecnt_i - request levels
//               usecnt_i - use count for alloc / set_usecnt
//               pg_addr_free_i, pg_addr_force_free_i, pg_addr_usecnt_i
//               done_o + per-type done pulses, free_last_usecnt_o
//               pg_addr_alloc_o - last allocated page (held)
//               no_mem_o - no free page or init running
//               err_o    - sticky double-free / stack-overflow flag
// Options     : SWC_ALLOC_DOUBLE_FREE_CHECK_EN - allocated-page bitmap that
//               rejects releases of unallocated pages and flags them on err_o.
// Revision    : 1.0 - initial release
// ============================================================================
module swc_page_allocator_core
    import swc_alloc_pkg::*;
#(
    parameter int g_page_addr_width = 10,
    parameter int g_usecnt_width    = 4
) (
    input  wire logic                         clk_i,
    input  wire logic                         rst_n_i,
    input  wire logic                         alloc_i,
    input  wire logic                         free_i,
    input  wire logic                         force_free_i,
    input  wire logic                         set_usecnt_i,
    input  wire logic [g_usecnt_width-1:0]    usecnt_i,
    input  wire logic [g_page_addr_width-1:0] pg_addr_free_i,
    input  wire logic [g_page_addr_width-1:0] pg_addr_force_free_i,
    input  wire logic [g_page_addr_width-1:0] pg_addr_usecnt_i,
    output logic                              done_o,
    output logic                              alloc_done_o,
    output logic                              free_done_o,
    output logic                              force_free_done_o,
    output logic                              set_usecnt_done_o,
    output logic                              free_last_usecnt_o,
    output logic      [g_page_addr_width-1:0] pg_addr_alloc_o,
    output logic                              no_mem_o,
    output logic                              err_o
);

    localparam int AW = g_page_addr_width;
    localparam int UW = g_usecnt_width;

    localparam logic [AW:0]   c_num_pages = {1'b1, {AW{1'b0}}};
    localparam logic [AW:0]   c_fc_one    = {{AW{1'b0}}, 1'b1};
    localparam logic [AW-1:0] c_last_page = {AW{1'b1}};
    localparam logic [AW-1:0] c_addr_one  = {{(AW-1){1'b0}}, 1'b1};
    localparam logic [UW-1:0] c_cnt_one   = {{(UW-1){1'b0}}, 1'b1};

    state_t          r_state;
    logic [AW-1:0]   r_init_idx;
    logic [AW:0]     r_free_count;
    req_t            r_req;
    logic [AW-1:0]   r_page;
    logic [UW-1:0]   r_usecnt;
    logic            r_alloc_ok;
    logic            r_done, r_alloc_done, r_free_done;
    logic            r_force_free_done, r_set_usecnt_done, r_free_last;
    logic [AW-1:0]   r_pg_addr_alloc;
    logic            r_no_mem, r_err;

    logic [3:0]      w_req_vec;
    req_t            w_pick;
    logic [AW-1:0]   w_req_page;
    logic            w_stack_we, w_ucnt_we;
    logic [AW-1:0]   w_stack_waddr, w_stack_wdata, w_stack_raddr, w_stack_rdata;
    logic [AW-1:0]   w_ucnt_waddr;
    logic [UW-1:0]   w_ucnt_wdata, w_ucnt_rdata;
    logic            w_push, w_pop, w_last, w_err_set, w_stack_full, w_page_ok;

    assign w_req_vec    = {set_usecnt_i, force_free_i, free_i, alloc_i};
    assign w_pick       = f_pick_req(w_req_vec);
    assign w_stack_full = (r_free_count == c_num_pages);
    // Top of stack; only meaningful while free_count > 0 (guarded by r_alloc_ok).
    assign w_stack_raddr = r_free_count[AW-1:0] - c_addr_one;

    always_comb begin
        w_req_page = '0;
        case (w_pick)
            REQ_FREE:         w_req_page = pg_addr_free_i;
            REQ_FORCE_FREE:   w_req_page = pg_addr_force_free_i;
            REQ_SET_USECOUNT: w_req_page = pg_addr_usecnt_i;
            default:          w_req_page = '0;
        endcase
    end

`ifdef SWC_ALLOC_DOUBLE_FREE_CHECK_EN
    logic [(1<<g_page_addr_width)-1:0] r_alloc_map;

    assign w_page_ok = r_alloc_map[r_page];

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_alloc_map <= '0;
        end else if (r_state == ST_WR) begin
            if (w_pop) begin
                r_alloc_map[w_stack_rdata] <= 1'b1;
            end else if (w_last) begin
                r_alloc_map[r_page] <= 1'b0;
            end
        end
    end
`else
    assign w_page_ok = 1'b1;
`endif

    // RAM write ports and the decisions of the WR cycle. Read data requested
    // in RD is available here.
    always_comb begin
        w_stack_we    = 1'b0;
        w_stack_waddr = r_free_count[AW-1:0];
        w_stack_wdata = r_page;
        w_ucnt_we     = 1'b0;
        w_ucnt_waddr  = r_page;
        w_ucnt_wdata  = '0;
        w_push        = 1'b0;
        w_pop         = 1'b0;
        w_last        = 1'b0;
        w_err_set     = 1'b0;
        case (r_state)
            ST_INIT: begin
                // stack[i] = N-1-i puts page 0 on top once init finishes.
                w_stack_we    = 1'b1;
                w_stack_waddr = r_init_idx;
                w_stack_wdata = c_last_page - r_init_idx;
                w_ucnt_we     = 1'b1;
                w_ucnt_waddr  = r_init_idx;
            end
            ST_WR: begin
                case (r_req)
                    REQ_ALLOC: begin
                        if (r_alloc_ok) begin
                            w_pop        = 1'b1;
                            w_ucnt_we    = 1'b1;
                            w_ucnt_waddr = w_stack_rdata;
                            w_ucnt_wdata = r_usecnt;
                        end
                    end
                    REQ_FREE: begin
                        if (!w_page_ok) begin
                            w_err_set = 1'b1;
                        end else if (w_ucnt_rdata == c_cnt_one) begin
                            w_ucnt_we = 1'b1;
                            w_push    = 1'b1;
                            w_last    = 1'b1;
                        end else if (w_ucnt_rdata != '0) begin
                            w_ucnt_we    = 1'b1;
                            w_ucnt_wdata = w_ucnt_rdata - c_cnt_one;
                        end else begin
`ifdef SWC_ALLOC_DOUBLE_FREE_CHECK_EN
                            w_err_set = 1'b1;
`endif
                        end
                    end
                    REQ_FORCE_FREE: begin
                        if (!w_page_ok) begin
                            w_err_set = 1'b1;
                        end else begin
                            w_ucnt_we = 1'b1;
                            w_push    = 1'b1;
                            w_last    = 1'b1;
                        end
                    end
                    default: begin
                        w_ucnt_we    = 1'b1;
                        w_ucnt_wdata = r_usecnt;
                    end
                endcase
                // A push onto a full stack can only come from a corrupt
                // initiator; drop it rather than wrap the stack pointer.
                if (w_push) begin
                    if (w_stack_full) begin
                        w_err_set = 1'b1;
                    end else begin
                        w_stack_we = 1'b1;
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state           <= ST_INIT;
            r_init_idx        <= '0;
            r_free_count      <= '0;
            r_req             <= REQ_ALLOC;
            r_page            <= '0;
            r_usecnt          <= '0;
            r_alloc_ok        <= 1'b0;
            r_done            <= 1'b0;
            r_alloc_done      <= 1'b0;
            r_free_done       <= 1'b0;
            r_force_free_done <= 1'b0;
            r_set_usecnt_done <= 1'b0;
            r_free_last       <= 1'b0;
            r_pg_addr_alloc   <= '0;
            r_no_mem          <= 1'b1;
            r_err             <= 1'b0;
        end else begin
            r_no_mem          <= (r_free_count == '0) || (r_state == ST_INIT);
            r_done            <= 1'b0;
            r_alloc_done      <= 1'b0;
            r_free_done       <= 1'b0;
            r_force_free_done <= 1'b0;
            r_set_usecnt_done <= 1'b0;
            r_free_last       <= 1'b0;
            if (w_err_set) begin
                r_err <= 1'b1;
            end
            case (r_state)
                ST_INIT: begin
                    r_init_idx <= r_init_idx + c_addr_one;
                    if (r_init_idx == c_last_page) begin
                        r_free_count <= c_num_pages;
                        r_state      <= ST_IDLE;
                    end
                end
                ST_IDLE: begin
                    if (|w_req_vec) begin
                        r_req      <= w_pick;
                        r_page     <= w_req_page;
                        r_usecnt   <= usecnt_i;
                        r_alloc_ok <= (r_free_count != '0);
                        r_state    <= ST_RD;
                    end
                end
                ST_RD: r_state <= ST_WR;
                ST_WR: begin
                    r_done            <= 1'b1;
                    r_alloc_done      <= w_pop;
                    r_free_done       <= (r_req == REQ_FREE);
                    r_force_free_done <= (r_req == REQ_FORCE_FREE);
                    r_set_usecnt_done <= (r_req == REQ_SET_USECOUNT);
                    r_free_last       <= w_last;
                    if (w_pop) begin
                        r_free_count    <= r_free_count - c_fc_one;
                        r_pg_addr_alloc <= w_stack_rdata;
                    end else if (w_push && !w_stack_full) begin
                        r_free_count <= r_free_count + c_fc_one;
                    end
                    r_state <= ST_RESP;
                end
                // Unconditionally back to IDLE so a request held through the
                // done cycle is not taken twice.
                ST_RESP: r_state <= ST_IDLE;
                default: r_state <= ST_INIT;
            endcase
        end
    end

    swc_alloc_ram #(
        .DATA_W (AW),
        .ADDR_W (AW)
    ) u_stack_ram (
        .clk     (clk_i),
        .i_we    (w_stack_we),
        .i_waddr (w_stack_waddr),
        .i_wdata (w_stack_wdata),
        .i_raddr (w_stack_raddr),
        .o_rdata (w_stack_rdata)
    );

    swc_alloc_ram #(
        .DATA_W (UW),
        .ADDR_W (AW)
    ) u_usecnt_ram (
        .clk     (clk_i),
        .i_we    (w_ucnt_we),
        .i_waddr (w_ucnt_waddr),
        .i_wdata (w_ucnt_wdata),
        .i_raddr (r_page),
        .o_rdata (w_ucnt_rdata)
    );

    assign done_o             = r_done;
    assign alloc_done_o       = r_alloc_done;
    assign free_done_o        = r_free_done;
    assign force_free_done_o  = r_force_free_done;
    assign set_usecnt_done_o  = r_set_usecnt_done;
    assign free_last_usecnt_o = r_free_last;
    assign pg_addr_alloc_o    = r_pg_addr_alloc;
    assign no_mem_o           = r_no_mem;
    assign err_o              = r_err;

endmodule
`default_nettype wire
